seq_det_sched: RTL and testbench
================================

Name: seq_det_sched

Overview:
- Shares one Moore "1011" sequence detector (overlapping, 1-bit serial input, registered output, active-high synchronous reset) among NREQ requesters.
- Each requester submits a WIDTH-bit word. The scheduler arbitrates, clears the detector, shifts the word in MSB-first, counts detector hits and reports a per-job result.
- Sits between software-visible requesters and the detector instance.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 16, bits per job word
- CNTW, 5, hit counter width; must satisfy 2^CNTW > WIDTH
- IDW, 2, requester-index width; must satisfy 2^IDW >= NREQ

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester level request
- req_data  in  NREQ*WIDTH  requester i's word at bits [i*WIDTH +: WIDTH]
- grant  out  NREQ  one-hot, one-cycle acknowledge; req_data of the granted requester is captured on that edge
- busy  out  1  high in every state except IDLE
- det_reset  out  1  drives detector reset (active-high)
- det_sequence_in  out  1  drives detector serial input
- det_out  in  1  detector output
- done  out  1  one-cycle result strobe
- done_id  out  IDW  index of the finished job
- hit_count  out  CNTW  number of detector hits for the job

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; grant=0, busy=0, done=0, done_id=0, hit_count=0, det_sequence_in=0.
  - det_reset=1 while reset is low, 0 after release.
  - Round-robin pointer=0. An in-flight job is discarded with no done.
- All outputs are registered.
- IDLE:
  - If any req is high on an edge: pick the winner by round-robin starting at pointer, capture its word into the shift register, set grant[winner] for the next cycle, set pointer=winner+1 mod NREQ, go to CLEAR.
  - Otherwise stay in IDLE.
- CLEAR (1 cycle): det_reset=1, det_sequence_in=0, grant pulse visible, counter cleared.
- SHIFT (WIDTH cycles, k=0..WIDTH-1):
  - det_sequence_in = word bit WIDTH-1-k; det_reset=0.
  - In cycles k>=1, if det_out=1 the counter increments. det_out in cycle k reflects bit k-1 because of the Moore one-cycle latency.
- DRAIN (1 cycle): det_sequence_in=0; sample det_out once more (reflects the last bit); increment counter if high.
- DONE (1 cycle): done=1, done_id=winner, hit_count=final counter; go to IDLE.
- done_id and hit_count hold until the next DONE.
- Latency: req sampled at edge E0 gives grant in cycle 1, SHIFT in cycles 2..WIDTH+1, DRAIN in cycle WIDTH+2, done in cycle WIDTH+3 (19 for WIDTH=16).
- Back-to-back jobs: the next arbitration happens in the IDLE cycle following DONE, so the minimum period is WIDTH+4 cycles.
- Requester protocol:
  - A requester must drop req in the cycle after its grant, otherwise it is served again.
  - Requests arriving while busy are held pending (level-sensitive); they are not lost.
  - Simultaneous requests are resolved by the round-robin pointer only.
- Counter saturates at 2^CNTW-1 (unreachable with legal parameters).
- No req while busy has any effect on the current job.

Optional Feature:
- Macro: SEQ_DET_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; the pointer is unused and held at 0.
- Undefined (default): round-robin as above.

Test Plan:
1. Single job: req[0]=1 with word 0xB6D8 (bits 1011011011011000). Expected: grant=0001 one cycle later; done 19 cycles after the sampling edge with done_id=0, hit_count=4.
2. Tail detection: word 0x000B (last four bits 1011). Expected: hit_count=1, proving the DRAIN sample. Word 0xFFFF: expected hit_count=0.
3. Contention: req=1111 all held, each dropped after its own grant. Expected grant order 0,1,2,3; consecutive done strobes spaced 20 cycles apart.
4. Fairness: req[0] held continuously and req[2] pulsed. Expected: after req[0] is served, req[2] is granted before req[0] is served again. With SEQ_DET_SCHED_FIXED_PRIO_EN defined, req[0] is served again first.
5. Reset mid-SHIFT: pull reset low at SHIFT k=5. Expected immediately: busy=0, det_reset=1, done never pulses, hit_count=0. After release, a new job completes normally.
6. Detector isolation: check det_reset=1 in exactly the CLEAR cycle of each job and det_sequence_in=0 in IDLE, CLEAR and DRAIN.

Source files
------------

// File: rtl/seq_det_sched_if.sv
// rtl/seq_det_sched_if.sv - requester-side bundle of the shared 1011 detector scheduler
interface seq_det_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int CNTW  = 5,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic                  done;
  logic [IDW-1:0]        done_id;
  logic [CNTW-1:0]       hit_count;

  modport master (
    output req, req_data,
    input  grant, busy, done, done_id, hit_count
  );

  modport slave (
    input  req, req_data,
    output grant, busy, done, done_id, hit_count
  );
endinterface

// File: rtl/seq_det_sched.sv
// rtl/seq_det_sched.sv - arbitrates NREQ requesters onto one Moore 1011 detector, counts hits per job
// Build option: SEQ_DET_SCHED_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module seq_det_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int CNTW  = 5,
  parameter int IDW   = 2
) (
  input  logic           clock_i,
  input  logic           reset_ni,
  seq_det_sched_if.slave bus,
  output logic           det_reset_o,
  output logic           det_sequence_in_o,
  input  logic           det_out_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [CNTW-1:0]   bitcnt_q, bitcnt_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [IDW-1:0]    done_id_q, done_id_d;
  logic [CNTW-1:0]   hit_q, hit_d;
  logic              det_rst_q, det_rst_d;
  logic              det_si_q, det_si_d;

  logic [IDW-1:0]    winner;
  logic [IDW-1:0]    ptr_next;
  logic [WIDTH-1:0]  win_word;
  logic [CNTW-1:0]   cnt_inc;

  // Descending scan so the last match is the one closest to the scan origin.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
`ifdef SEQ_DET_SCHED_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[IDW'(i)]) winner = IDW'(i);
    end
    ptr_next = '0;
`else
    for (int o = NREQ - 1; o >= 0; o--) begin
      idx = int'(ptr_q) + o;
      if (idx >= NREQ) idx = idx - NREQ;
      if (bus.req[IDW'(idx)]) winner = IDW'(idx);
    end
    ptr_next = (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
`endif
  end

  always_comb begin
    win_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IDW'(i)) win_word = bus.req_data[i*WIDTH +: WIDTH];
    end
  end

  assign cnt_inc = (det_out_i && (cnt_q != {CNTW{1'b1}})) ? cnt_q + 1'b1 : cnt_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    grant_d   = '0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    hit_d     = hit_q;
    det_rst_d = 1'b0;
    det_si_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          state_d   = S_CLEAR;
          id_d      = winner;
          shreg_d   = win_word;
          grant_d   = NREQ'(1) << winner;
          ptr_d     = ptr_next;
          cnt_d     = '0;
          det_rst_d = 1'b1;
        end
      end
      S_CLEAR: begin
        state_d  = S_SHIFT;
        det_si_d = shreg_q[WIDTH-1];
        shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
        bitcnt_d = '0;
      end
      S_SHIFT: begin
        // det_out lags the serial input by one cycle, so bit 0's cycle sees only the cleared state.
        if (bitcnt_q != '0) cnt_d = cnt_inc;
        if (bitcnt_q == CNTW'(WIDTH - 1)) begin
          state_d = S_DRAIN;
        end else begin
          det_si_d = shreg_q[WIDTH-1];
          shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
          bitcnt_d = bitcnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        state_d   = S_DONE;
        cnt_d     = cnt_inc;
        done_d    = 1'b1;
        done_id_d = id_q;
        hit_d     = cnt_inc;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      cnt_q     <= '0;
      id_q      <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      hit_q     <= '0;
      det_rst_q <= 1'b1;
      det_si_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      hit_q     <= hit_d;
      det_rst_q <= det_rst_d;
      det_si_q  <= det_si_d;
    end
  end

  assign bus.grant         = grant_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.done_id       = done_id_q;
  assign bus.hit_count     = hit_q;
  assign det_reset_o       = det_rst_q;
  assign det_sequence_in_o = det_si_q;

endmodule

// File: tb/tb_seq_det_sched.sv
// tb/tb_seq_det_sched.sv - directed bench for seq_det_sched with a behavioural 1011 detector
module tb_seq_det_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int CNTW  = 5;
  localparam int IDW   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic det_reset;
  logic det_si;
  logic det_out;
  logic [2:0] dstate = 3'd0;

  always #5 clk = ~clk;

  seq_det_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW), .IDW(IDW)) bus ();

  seq_det_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW), .IDW(IDW)) dut (
    .clock_i           (clk),
    .reset_ni          (rst_n),
    .bus               (bus.slave),
    .det_reset_o       (det_reset),
    .det_sequence_in_o (det_si),
    .det_out_i         (det_out)
  );

  // Overlapping Moore 1011 detector: states 0,1,10,101,1011.
  always @(posedge clk) begin
    if (det_reset) dstate <= 3'd0;
    else begin
      case (dstate)
        3'd0:    dstate <= det_si ? 3'd1 : 3'd0;
        3'd1:    dstate <= det_si ? 3'd1 : 3'd2;
        3'd2:    dstate <= det_si ? 3'd3 : 3'd0;
        3'd3:    dstate <= det_si ? 3'd4 : 3'd2;
        3'd4:    dstate <= det_si ? 3'd1 : 3'd2;
        default: dstate <= 3'd0;
      endcase
    end
  end
  assign det_out = (dstate == 3'd4);

  typedef struct {
    int          id;
    logic [15:0] word;
    logic [4:0]  hits;
  } vec_t;

  vec_t vecs [8];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v == (NREQ'(1) << i)) r = i;
    return r;
  endfunction

  task automatic set_word(input int id, input logic [15:0] word);
    logic [NREQ*WIDTH-1:0] d;
    d = bus.req_data;
    d = d & ~((NREQ*WIDTH)'(16'hFFFF) << (id * WIDTH));
    d = d | ((NREQ*WIDTH)'(word) << (id * WIDTH));
    bus.req_data = d;
  endtask

  task automatic do_reset;
    bus.req = '0;
    rst_n   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic run_job(input int id, input logic [15:0] word, input logic [4:0] hits);
    int bad_rst, bad_si, bad_busy, bad_done;
    logic [15:0] w;
    logic exp_si;
    bad_rst = 0; bad_si = 0; bad_busy = 0; bad_done = 0;
    set_word(id, word);
    bus.req = bus.req | (NREQ'(1) << id);
    for (int c = 1; c <= 19; c++) begin
      tick();
      if (c == 1) begin
        check("grant_onehot", 32'(bus.grant), 32'(NREQ'(1) << id));
        bus.req = bus.req & ~(NREQ'(1) << id);
      end
      w = word << (c - 2);
      exp_si = (c >= 2 && c <= 17) ? w[15] : 1'b0;
      if (det_reset !== (c == 1)) bad_rst++;
      if (det_si !== exp_si) bad_si++;
      if (bus.busy !== 1'b1) bad_busy++;
      if (bus.done !== (c == 19)) bad_done++;
      if (c == 19) begin
        check("done_id", 32'(bus.done_id), 32'(id));
        check("hit_count", 32'(bus.hit_count), 32'(hits));
      end
    end
    check("det_reset_window", 32'(bad_rst), 0);
    check("det_seq_in_bits", 32'(bad_si), 0);
    check("busy_window", 32'(bad_busy), 0);
    check("done_timing", 32'(bad_done), 0);
    tick();
    check("idle_busy", 32'(bus.busy), 0);
    check("idle_det_idle", 32'({det_reset, det_si, bus.done}), 0);
  endtask

  initial begin
    int order [4];
    int dcyc [4];
    int ng, nd, g, g0;
    int gseq [3];
    int dones;

    vecs[0] = '{0, 16'hB6D8, 5'd4};
    vecs[1] = '{1, 16'h000B, 5'd1};
    vecs[2] = '{2, 16'hFFFF, 5'd0};
    vecs[3] = '{3, 16'hBBBB, 5'd4};
    vecs[4] = '{0, 16'h2D2D, 5'd2};
    vecs[5] = '{1, 16'hDDDD, 5'd3};
    vecs[6] = '{2, 16'hB000, 5'd1};
    vecs[7] = '{3, 16'h0000, 5'd0};

    bus.req      = '0;
    bus.req_data = '0;
    tick();
    tick();
    check("rst_outputs", 32'({bus.grant, bus.busy, bus.done, bus.done_id, bus.hit_count, det_si}), 0);
    check("rst_det_reset", 32'(det_reset), 1);
    rst_n = 1'b1;
    tick();
    check("post_rst_det_reset", 32'(det_reset), 0);
    check("post_rst_busy", 32'(bus.busy), 0);

    for (int i = 0; i < 8; i++) run_job(vecs[i].id, vecs[i].word, vecs[i].hits);

    // All four requesters at once: served in pointer order, done every 20 cycles.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_word(i, vecs[i].word);
    bus.req = '1;
    ng = 0; nd = 0;
    for (int cyc = 0; cyc < 200 && nd < 4; cyc++) begin
      tick();
      g = onehot_idx(bus.grant);
      if (g >= 0 && ng < 4) begin
        order[ng] = g;
        ng++;
        bus.req = bus.req & ~(NREQ'(1) << g);
      end
      if (bus.done && nd < 4) begin
        dcyc[nd] = cyc;
        check("contention_done_id", 32'(bus.done_id), 32'(nd));
        check("contention_hits", 32'(bus.hit_count), 32'(vecs[nd].hits));
        nd++;
      end
    end
    check("contention_done_count", 32'(nd), 4);
    for (int i = 0; i < 4; i++) if (i < ng) check("contention_order", 32'(order[i]), 32'(i));
    for (int i = 0; i < 3; i++) if (i + 1 < nd) check("contention_spacing", 32'(dcyc[i+1] - dcyc[i]), 20);
    bus.req = '0;

    // req[0] held, req[2] raised during req[0]'s job.
    do_reset();
    bus.req = 4'b0001;
    ng = 0; g0 = 0;
    for (int cyc = 0; cyc < 150 && ng < 3; cyc++) begin
      tick();
      g = onehot_idx(bus.grant);
      if (g >= 0) begin
        gseq[ng] = g;
        ng++;
        if (g == 0) begin
          g0++;
          if (ng == 1) bus.req = bus.req | 4'b0100;
          if (g0 == 2) bus.req = bus.req & 4'b1110;
        end
        if (g == 2) bus.req = bus.req & 4'b1011;
      end
    end
    check("fair_grant_count", 32'(ng), 3);
    check("fair_first", 32'(gseq[0]), 0);
`ifdef SEQ_DET_SCHED_FIXED_PRIO_EN
    check("fair_second", 32'(gseq[1]), 0);
    check("fair_third", 32'(gseq[2]), 2);
`else
    check("fair_second", 32'(gseq[1]), 2);
    check("fair_third", 32'(gseq[2]), 0);
`endif
    bus.req = '0;

    // Reset during SHIFT k=5 of a job, after a prior job left hit_count=4.
    do_reset();
    run_job(0, 16'hB6D8, 5'd4);
    set_word(1, 16'hBBBB);
    bus.req = 4'b0010;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) bus.req = '0;
    end
    check("midjob_busy", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_det_reset", 32'(det_reset), 1);
    check("midrst_hit_count", 32'(bus.hit_count), 0);
    check("midrst_done_grant", 32'({bus.done, bus.grant}), 0);
    tick();
    tick();
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus.done) dones++;
    end
    check("midrst_no_done", 32'(dones), 0);
    run_job(1, 16'hBBBB, 5'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
